pll_rst_seq: RTL and testbench
==============================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 256: number of consecutive synchronized-locked cycles required before lock is accepted.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024: number of cycles reset stays asserted after lock is accepted or after a soft request.
REQ-003 SHALL have parameter LOSS_W, default 8: width of the lock-loss counter.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pll_locked, input, 1: PLL lock indication, asynchronous to clk.
REQ-007 SHALL have port soft_rst_req, input, 1: synchronous one-cycle request to re-run the reset hold.
REQ-008 SHALL have port sys_rst_n, output, 1: registered active-low reset released to downstream logic.
REQ-009 SHALL have port rst_done, output, 1: high while in RUN; equals sys_rst_n.
REQ-010 SHALL have port state_o, output, 2: current state encoding (WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3).
REQ-011 SHALL have port loss_cnt, output, LOSS_W: count of lock losses seen in RUN, saturating.

Function
REQ-012 SHALL pass pll_locked through a 2-flop synchronizer; lock_s is the second flop's output, and the FSM uses only lock_s.
REQ-013 In WAIT_LOCK, SHALL hold sys_rst_n=0, clear the counter, and go to FILTER on the first cycle lock_s=1.
REQ-014 In FILTER, SHALL increment the counter each cycle lock_s=1, and return to WAIT_LOCK with the counter cleared on any cycle lock_s=0.
REQ-015 In FILTER, SHALL go to HOLD, clearing the counter, when the counter reaches LOCK_CYCLES-1 with lock_s=1; lock_s must be high for exactly LOCK_CYCLES consecutive FILTER cycles.
REQ-016 In HOLD, SHALL keep sys_rst_n=0 and increment the counter; after HOLD_CYCLES cycles in HOLD it SHALL go to RUN.
REQ-017 In HOLD, SHALL go to WAIT_LOCK on lock_s=0.
REQ-018 sys_rst_n SHALL be registered from the next state, so it rises on the same edge that enters RUN.
REQ-019 In RUN, SHALL keep sys_rst_n=1; on lock_s=0 it SHALL go to WAIT_LOCK with sys_rst_n=0 on that same edge, and increment loss_cnt, saturating at all-ones.
REQ-020 In RUN, soft_rst_req=1 SHALL cause entry to HOLD with the counter cleared and sys_rst_n=0 on the next edge.
REQ-021 If lock_s=0 and soft_rst_req=1 occur in the same RUN cycle, lock loss SHALL win: next state WAIT_LOCK, loss_cnt incremented.
REQ-022 In HOLD, soft_rst_req SHALL restart the HOLD count from 0.
REQ-023 soft_rst_req SHALL be ignored in WAIT_LOCK and FILTER.
REQ-024 The counter SHALL be sized ceil(log2(max(LOCK_CYCLES,HOLD_CYCLES)))+1 bits and SHALL never wrap within a state.
REQ-025 loss_cnt SHALL be cleared only by rst_n.

Reset
REQ-026 When rst_n=0, SHALL asynchronously force state=WAIT_LOCK, counter=0, synchronizer flops=0, sys_rst_n=0, rst_done=0, and loss_cnt=0.
REQ-027 Deassertion of rst_n SHALL take effect on the next clk edge; an rst_n assertion mid-HOLD or mid-RUN SHALL immediately return all outputs to their reset values.

Verification
REQ-028 Test 1: LOCK_CYCLES=4 and HOLD_CYCLES=8, with pll_locked tied high from reset release -> sys_rst_n rises exactly 2+1+4+8 cycles after the first sampled-high edge (±0), and state_o=3 on that edge.
REQ-029 Test 2: pll_locked drops for 1 cycle after 3 FILTER cycles -> return to WAIT_LOCK, the filter restarts, and the release is delayed by the glitch position plus the sync latency.
REQ-030 Test 3: in RUN, pll_locked is deasserted -> sys_rst_n=0 within 3 edges (2 sync + 1), loss_cnt goes 0->1, and relock reruns the full sequence.
REQ-031 Test 4: in RUN, a soft_rst_req pulse -> sys_rst_n is low for exactly HOLD_CYCLES cycles and loss_cnt is unchanged; a second pulse mid-HOLD extends the low time to its position plus HOLD_CYCLES.
REQ-032 Test 5: in RUN, soft_rst_req coincides with lock_s falling -> state_o=0 and loss_cnt increments.
REQ-033 Test 6: with LOSS_W=2, force 5 lock losses -> loss_cnt saturates at 3; asserting rst_n mid-HOLD clears every output asynchronously before the next clk edge.

Source files
------------

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: waits for a stable PLL lock, holds downstream reset
// for a fixed time, then releases it. Lock loss or a soft request re-runs
// the sequence; lock losses seen while running are counted.
module pll_rst_seq #(
  parameter int LOCK_CYCLES = 256,
  parameter int HOLD_CYCLES = 1024,
  parameter int LOSS_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              soft_rst_req,
  output logic              sys_rst_n,
  output logic              rst_done,
  output logic [1:0]        state_o,
  output logic [LOSS_W-1:0] loss_cnt
);

  localparam int MAX_CYC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  // One spare bit so the terminal value never wraps within a state.
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = {LOSS_W{1'b1}};

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sync1, lock_s;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  // State, counter and registered reset output (driven from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      sys_rst_n <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sys_rst_n <= (state_nx == RUN);
    end
  end

  // Next-state logic; lock loss always takes priority over soft requests.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nx = '0;
        if (lock_s) state_nx = FILTER;
      end
      FILTER: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (soft_rst_req) begin
          cnt_nx = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_nx = '0;
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
        end else if (soft_rst_req) begin
          state_nx = HOLD;
        end
      end
      default: begin
        state_nx = WAIT_LOCK;
        cnt_nx   = '0;
      end
    endcase
  end

  // Saturating count of lock losses observed while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (state == RUN && !lock_s && loss_cnt != LOSS_MAX) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  assign rst_done = sys_rst_n;
  assign state_o  = state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: directed scenarios plus a randomized
// run compared against a lock-streak based reference model.
module tb_pll_rst_seq;

  localparam int L   = 4;
  localparam int H   = 8;
  localparam int LW  = 2;
  localparam int LHS = 1 + L + H; // consecutive locked samples needed for release

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          soft_rst_req = 1'b0;
  logic          sys_rst_n;
  logic          rst_done;
  logic [1:0]    state_o;
  logic [LW-1:0] loss_cnt;

  int checks = 0;
  int errors = 0;

  pll_rst_seq #(.LOCK_CYCLES(L), .HOLD_CYCLES(H), .LOSS_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .sys_rst_n(sys_rst_n), .rst_done(rst_done), .state_o(state_o), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model. The FSM sees pll_locked two edges late; what matters is
  // the length of the current run of locked samples. Release needs LHS of them;
  // a soft request while holding/running pushes release to H edges later.
  logic          m_s1, m_samp, m_out;
  int            m_edge, m_streak, m_rel;
  logic [LW-1:0] m_loss;
  int            n_streak, n_rel;

  assign n_streak = m_samp ? ((m_streak < 1000) ? m_streak + 1 : m_streak) : 0;
  assign n_rel    = (soft_rst_req && m_samp && m_streak >= 1 + L) ? m_edge + H : m_rel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= 1'b0; m_samp <= 1'b0; m_out <= 1'b0;
      m_edge <= 0; m_streak <= 0; m_rel <= 0; m_loss <= '0;
    end else begin
      m_s1     <= pll_locked;
      m_samp   <= m_s1;
      m_edge   <= m_edge + 1;
      m_streak <= n_streak;
      m_rel    <= n_rel;
      m_out    <= (n_streak >= LHS) && (m_edge >= n_rel);
      if (!m_samp && m_out && m_loss != {LW{1'b1}}) m_loss <= m_loss + 1'b1;
    end
  end

  function automatic logic [1:0] m_state();
    if (m_streak == 0) return 2'd0;
    if (m_streak <= L) return 2'd1;
    return m_out ? 2'd3 : 2'd2;
  endfunction

  // Hold reset for two cycles, release on a falling edge.
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; pll_locked = 1'b0; soft_rst_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Lock the PLL and wait (bounded) for reset release.
  task automatic lock_up();
    int n;
    pll_locked = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sys_rst_n && n < 60);
    checks++;
    if (sys_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL lock_up_timeout: sys_rst_n=%b required 1 within 60 cycles", sys_rst_n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; pll_locked = 1'b1; soft_rst_req = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n: got %b required 0", sys_rst_n); end
    if (rst_done !== 1'b0)  begin errors++; $display("FAIL reset_rst_done: got %b required 0", rst_done); end
    if (state_o !== 2'd0)   begin errors++; $display("FAIL reset_state: got %0d required 0", state_o); end
    if (loss_cnt !== '0)    begin errors++; $display("FAIL reset_loss: got %0d required 0", loss_cnt); end
    soft_rst_req = 1'b0;
  endtask

  // Locked from reset release: release on edge 2+1+L+H counting the first
  // edge that samples pll_locked as edge 1.
  task automatic test_lock_timing();
    int n;
    @(negedge clk);
    rst_n = 1'b0; pll_locked = 1'b0; soft_rst_req = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1; rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sys_rst_n && n < 60);
    checks += 3;
    if (n !== 2 + 1 + L + H) begin errors++; $display("FAIL lock_timing: released at edge %0d required %0d", n, 2 + 1 + L + H); end
    if (state_o !== 2'd3)    begin errors++; $display("FAIL lock_state: got %0d required 3", state_o); end
    if (rst_done !== 1'b1)   begin errors++; $display("FAIL lock_rst_done: got %b required 1", rst_done); end
  endtask

  // One-cycle dropout sampled on edge g lands on the 4th filter cycle.
  task automatic test_glitch();
    int n;
    int g = 5;
    @(negedge clk);
    rst_n = 1'b0; pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1; rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 6) begin
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL glitch_filter: got %0d required 1", state_o); end
      end
      if (n == 7) begin
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL glitch_wait: got %0d required 0", state_o); end
      end
      pll_locked = (n + 1 != g);
    end while (!sys_rst_n && n < 80);
    checks++;
    if (n !== g + 2 + LHS) begin errors++; $display("FAIL glitch_release: edge %0d required %0d", n, g + 2 + LHS); end
  endtask

  task automatic test_lock_loss();
    int n;
    reset_dut();
    lock_up();
    pll_locked = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sys_rst_n && n < 10);
    checks += 3;
    if (n !== 3)          begin errors++; $display("FAIL loss_latency: %0d edges required 3", n); end
    if (state_o !== 2'd0) begin errors++; $display("FAIL loss_state: got %0d required 0", state_o); end
    if (loss_cnt !== 2'd1) begin errors++; $display("FAIL loss_count: got %0d required 1", loss_cnt); end
    pll_locked = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sys_rst_n && n < 60);
    checks += 2;
    if (n !== 2 + 1 + L + H) begin errors++; $display("FAIL relock_timing: edge %0d required %0d", n, 2 + 1 + L + H); end
    if (loss_cnt !== 2'd1)   begin errors++; $display("FAIL relock_loss: got %0d required 1", loss_cnt); end
  endtask

  task automatic test_soft();
    int n, low, p;
    reset_dut();
    lock_up();
    soft_rst_req = 1'b1;
    low = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      soft_rst_req = 1'b0;
      if (n == 1) begin
        checks++;
        if (state_o !== 2'd2) begin errors++; $display("FAIL soft_state: got %0d required 2", state_o); end
      end
      if (!sys_rst_n) low++;
    end while (!sys_rst_n && n < 60);
    checks += 2;
    if (low !== H)         begin errors++; $display("FAIL soft_low: %0d cycles required %0d", low, H); end
    if (loss_cnt !== 2'd0) begin errors++; $display("FAIL soft_loss: got %0d required 0", loss_cnt); end
    // Second pulse p edges into HOLD restarts the count.
    p = $urandom_range(1, H - 1);
    soft_rst_req = 1'b1;
    low = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      soft_rst_req = (n == p);
      if (!sys_rst_n) low++;
    end while (!sys_rst_n && n < 60);
    checks++;
    if (low !== p + H) begin errors++; $display("FAIL soft_extend: %0d cycles required %0d (p=%0d)", low, p + H, p); end
  endtask

  task automatic test_soft_vs_loss();
    reset_dut();
    lock_up();
    pll_locked = 1'b0;           // reaches lock_s on edge 3
    repeat (2) @(negedge clk);
    soft_rst_req = 1'b1;         // sampled on edge 3 as well
    @(negedge clk);
    soft_rst_req = 1'b0;
    checks += 3;
    if (state_o !== 2'd0)  begin errors++; $display("FAIL coincide_state: got %0d required 0", state_o); end
    if (loss_cnt !== 2'd1) begin errors++; $display("FAIL coincide_loss: got %0d required 1", loss_cnt); end
    if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL coincide_rst: got %b required 0", sys_rst_n); end
  endtask

  task automatic test_saturate();
    int exp_loss;
    reset_dut();
    lock_up();
    for (int i = 1; i <= 5; i++) begin
      pll_locked = 1'b0;
      repeat (4) @(negedge clk);
      exp_loss = (i > 3) ? 3 : i;
      checks++;
      if (loss_cnt !== LW'(exp_loss)) begin errors++; $display("FAIL sat_loss_%0d: got %0d required %0d", i, loss_cnt, exp_loss); end
      lock_up();
    end
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== 2'd2) begin errors++; $display("FAIL async_pre_hold: got %0d required 2", state_o); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL async_sys_rst_n: got %b required 0", sys_rst_n); end
    if (rst_done !== 1'b0)  begin errors++; $display("FAIL async_rst_done: got %b required 0", rst_done); end
    if (state_o !== 2'd0)   begin errors++; $display("FAIL async_state: got %0d required 0", state_o); end
    if (loss_cnt !== '0)    begin errors++; $display("FAIL async_loss: got %0d required 0", loss_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int errs0 = errors;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks += 4;
      if (sys_rst_n !== m_out) begin errors++; $display("FAIL rnd_sys_rst_n @%0d: got %b required %b", c, sys_rst_n, m_out); end
      if (rst_done !== m_out)  begin errors++; $display("FAIL rnd_rst_done @%0d: got %b required %b", c, rst_done, m_out); end
      if (state_o !== m_state()) begin errors++; $display("FAIL rnd_state @%0d: got %0d required %0d", c, state_o, m_state()); end
      if (loss_cnt !== m_loss) begin errors++; $display("FAIL rnd_loss @%0d: got %0d required %0d", c, loss_cnt, m_loss); end
      if (errors - errs0 > 20) break;
      if (pll_locked) pll_locked = ($urandom_range(0, 39) != 0);
      else            pll_locked = ($urandom_range(0, 3) == 0);
      soft_rst_req = ($urandom_range(0, 24) == 0);
    end
    soft_rst_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock_timing();
    test_glitch();
    test_lock_loss();
    test_soft();
    test_soft_vs_loss();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
